// File: rtl/line_frame_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : line_frame_sequencer_pkg
// Description : Shared state encoding and default frame constants for the
//               line/frame sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package line_frame_sequencer_pkg;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_GAP  = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    localparam int c_LINES_NORM = 1024;
    localparam int c_LINES_TEST = 4;
    localparam int c_GAP_CYC    = 8;

    // Terminal values of the 12-bit pixel counter on the far side of endLine
    localparam int c_PIX_TERM_NORM = 4095;
    localparam int c_PIX_TERM_TEST = 1289;

endpackage
`default_nettype wire

// File: rtl/line_frame_sequencer_gap_timer.sv
`default_nettype none
// ============================================================================
// Module      : line_frame_sequencer_gap_timer
// Description : Load/decrement counter with a zero flag, times the blanking
//               gap between lines.
// Revision    : 1.0 - initial release
// ============================================================================
module line_frame_sequencer_gap_timer #(
    parameter int GAP_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [GAP_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [GAP_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec) begin
            r_cnt <= r_cnt - GAP_W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/line_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : line_frame_sequencer
// Description : Drives the pixel counter enable, counts lines, inserts a
//               blanking gap between lines and flags frame completion.
// Revision    : 1.0 - initial release
// ============================================================================
module line_frame_sequencer
    import line_frame_sequencer_pkg::*;
#(
    parameter int LINE_W     = 11,
    parameter int LINES_NORM = c_LINES_NORM,
    parameter int LINES_TEST = c_LINES_TEST,
    parameter int GAP_W      = 8,
    parameter int GAP_CYC    = c_GAP_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              test_in,
    input  logic              loop,
    input  logic              abort,
    input  logic              endLine,
    output logic              b12_enb,
    output logic              test,
    output logic [LINE_W-1:0] line_cnt,
    output logic              endFrame,
    output logic              busy,
    output logic              err
);

    localparam logic [LINE_W-1:0] c_LAST_NORM = LINE_W'(LINES_NORM - 1);
    localparam logic [LINE_W-1:0] c_LAST_TEST = LINE_W'(LINES_TEST - 1);
    localparam logic [GAP_W-1:0]  c_GAP_LOAD  = GAP_W'(GAP_CYC - 1);

    logic [1:0]        r_state, w_state_nx;
    logic              r_enb, w_enb_nx;
    logic              r_test_q, w_test_nx;
    logic [LINE_W-1:0] r_line, w_line_nx;
    logic              r_endf, w_endf_nx;
    logic              r_busy;
    logic              r_err, w_err_nx;
    logic              w_gap_load, w_gap_dec, w_gap_zero;
    logic [LINE_W-1:0] w_last_line;

    assign w_last_line = r_test_q ? c_LAST_TEST : c_LAST_NORM;

    line_frame_sequencer_gap_timer #(
        .GAP_W (GAP_W)
    ) u_gap_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_gap_load),
        .i_load_val (c_GAP_LOAD),
        .i_dec      (w_gap_dec),
        .o_zero     (w_gap_zero)
    );

    always_comb begin
        w_state_nx = r_state;
        w_enb_nx   = r_enb;
        w_test_nx  = r_test_q;
        w_line_nx  = r_line;
        w_endf_nx  = 1'b0;
        w_err_nx   = r_err;
        w_gap_load = 1'b0;
        w_gap_dec  = 1'b0;

        if (abort) begin
            w_state_nx = c_ST_IDLE;
            w_enb_nx   = 1'b0;
            w_line_nx  = '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        w_test_nx  = test_in;
                        w_line_nx  = '0;
                        w_enb_nx   = 1'b1;
                        w_err_nx   = 1'b0;
                        w_state_nx = c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    if (endLine) begin
                        w_enb_nx = 1'b0;
                        if (r_line == w_last_line) begin
                            w_endf_nx  = 1'b1;
                            w_state_nx = c_ST_DONE;
                        end else begin
                            w_line_nx  = r_line + LINE_W'(1);
                            w_gap_load = 1'b1;
                            w_state_nx = c_ST_GAP;
                        end
                    end
                end
                c_ST_GAP: begin
                    if (w_gap_zero) begin
                        w_enb_nx   = 1'b1;
                        w_state_nx = c_ST_RUN;
                    end else begin
                        w_gap_dec = 1'b1;
                    end
                end
                default: begin
                    if (loop) begin
                        w_line_nx  = '0;
                        w_gap_load = 1'b1;
                        w_state_nx = c_ST_GAP;
                    end else begin
                        w_state_nx = c_ST_IDLE;
                    end
                end
            endcase
        end

        // Error sources take priority over the clear from an accepted start
        if (endLine && (r_state != c_ST_RUN)) begin
            w_err_nx = 1'b1;
        end
        if (start && r_busy && !abort) begin
            w_err_nx = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_enb    <= 1'b0;
            r_test_q <= 1'b0;
            r_line   <= '0;
            r_endf   <= 1'b0;
            r_busy   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_enb    <= w_enb_nx;
            r_test_q <= w_test_nx;
            r_line   <= w_line_nx;
            r_endf   <= w_endf_nx;
            r_busy   <= (w_state_nx != c_ST_IDLE);
            r_err    <= w_err_nx;
        end
    end

    assign b12_enb  = r_enb;
    assign test     = r_test_q;
    assign line_cnt = r_line;
    assign endFrame = r_endf;
    assign busy     = r_busy;
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_line_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_frame_sequencer
// Description : Directed self-checking bench with a pixel-counter model that
//               raises endLine on every 10th enabled cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_frame_sequencer;

    localparam int LINE_W     = 11;
    localparam int LINES_NORM = 1024;
    localparam int LINES_TEST = 4;
    localparam int GAP_W      = 8;
    localparam int GAP_CYC    = 8;

    if (LINES_NORM > 2**LINE_W || LINES_TEST > 2**LINE_W) begin : g_lim_check
        $fatal(1, "illegal configuration: line limit exceeds LINE_W range");
    end

    logic              clk = 1'b0;
    logic              rst, start, test_in, loop, abort, force_el;
    logic              endLine;
    logic              b12_enb, test, endFrame, busy, err;
    logic [LINE_W-1:0] line_cnt;
    logic [11:0]       pix;
    int                n_assert = 0;
    int                n_fail   = 0;

    always #5 clk = ~clk;

    line_frame_sequencer #(
        .LINE_W     (LINE_W),
        .LINES_NORM (LINES_NORM),
        .LINES_TEST (LINES_TEST),
        .GAP_W      (GAP_W),
        .GAP_CYC    (GAP_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .test_in  (test_in),
        .loop     (loop),
        .abort    (abort),
        .endLine  (endLine),
        .b12_enb  (b12_enb),
        .test     (test),
        .line_cnt (line_cnt),
        .endFrame (endFrame),
        .busy     (busy),
        .err      (err)
    );

    // Pixel counter model: clears while disabled, endLine on count 9
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          pix <= '0;
        else if (!b12_enb) pix <= '0;
        else              pix <= pix + 12'd1;
    end
    assign endLine = force_el | (b12_enb && (pix == 12'd9));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Entered on the first RUN cycle of line 0; returns on the DONE cycle
    task automatic check_frame();
        int n;
        for (int k = 0; k < LINES_TEST; k++) begin
            chk("run_enb", 32'(b12_enb), 32'd1);
            chk("run_line", 32'(line_cnt), 32'(k));
            chk("run_test", 32'(test), 32'd1);
            repeat (9) tick();
            chk("endline_line", 32'(line_cnt), 32'(k));
            chk("no_early_endframe", 32'(endFrame), 32'd0);
            tick();
            if (k < LINES_TEST - 1) begin
                chk("gap_line", 32'(line_cnt), 32'(k + 1));
                chk("gap_busy", 32'(busy), 32'd1);
                n = 0;
                while (b12_enb == 1'b0 && n < 30) begin
                    n++;
                    tick();
                end
                chk("gap_len", 32'(n), 32'd8);
            end else begin
                chk("done_endframe", 32'(endFrame), 32'd1);
                chk("done_enb", 32'(b12_enb), 32'd0);
                chk("done_busy", 32'(busy), 32'd1);
                chk("done_line", 32'(line_cnt), 32'(LINES_TEST - 1));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; test_in = 1'b0; loop = 1'b0;
        abort = 1'b0; force_el = 1'b0;
        repeat (3) tick();
        chk("rst_enb", 32'(b12_enb), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_line", 32'(line_cnt), 32'd0);
        chk("rst_endframe", 32'(endFrame), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_test", 32'(test), 32'd0);
        rst = 1'b0;
        tick();

        // Single test-mode frame
        start = 1'b1; test_in = 1'b1;
        tick();
        start = 1'b0; test_in = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        check_frame();
        tick();
        chk("idle_endframe", 32'(endFrame), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_err", 32'(err), 32'd0);

        // Two looped frames
        loop = 1'b1; start = 1'b1; test_in = 1'b1;
        tick();
        start = 1'b0; test_in = 1'b0;
        check_frame();
        tick();
        chk("loop_gap_line", 32'(line_cnt), 32'd0);
        chk("loop_gap_enb", 32'(b12_enb), 32'd0);
        chk("loop_gap_busy", 32'(busy), 32'd1);
        chk("loop_gap_endframe", 32'(endFrame), 32'd0);
        loop = 1'b0;
        n = 0;
        while (b12_enb == 1'b0 && n < 30) begin
            n++;
            tick();
        end
        chk("loop_gap_len", 32'(n), 32'd8);
        check_frame();
        tick();
        chk("loop_end_busy", 32'(busy), 32'd0);

        // Abort in the gap before line 2
        start = 1'b1; test_in = 1'b1;
        tick();
        start = 1'b0;
        repeat (29) tick();
        chk("pre_abort_line", 32'(line_cnt), 32'd2);
        chk("pre_abort_enb", 32'(b12_enb), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_enb", 32'(b12_enb), 32'd0);
        chk("abort_line", 32'(line_cnt), 32'd0);
        chk("abort_endframe", 32'(endFrame), 32'd0);
        repeat (10) tick();
        chk("abort_stays_idle", 32'(busy | b12_enb | endFrame), 32'd0);

        // Protocol errors
        force_el = 1'b1;
        tick();
        force_el = 1'b0;
        chk("err_endline_idle", 32'(err), 32'd1);
        start = 1'b1; test_in = 1'b1;
        tick();
        start = 1'b0;
        chk("err_clear_start", 32'(err), 32'd0);
        repeat (2) tick();
        start = 1'b1; test_in = 1'b0;
        tick();
        start = 1'b0;
        chk("err_start_busy", 32'(err), 32'd1);
        chk("err_start_test_kept", 32'(test), 32'd1);
        chk("err_start_line", 32'(line_cnt), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("err_sticky_abort", 32'(err), 32'd1);
        start = 1'b1; test_in = 1'b1;
        tick();
        start = 1'b0;
        chk("err_clear_again", 32'(err), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // Start with abort from IDLE
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("sa_busy", 32'(busy), 32'd0);
        chk("sa_enb", 32'(b12_enb), 32'd0);
        chk("sa_err", 32'(err), 32'd0);

        // Asynchronous reset mid-line
        start = 1'b1; test_in = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        chk("pre_rst_line", 32'(line_cnt), 32'd1);
        chk("pre_rst_enb", 32'(b12_enb), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_enb", 32'(b12_enb), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_line", 32'(line_cnt), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
